// File: rtl/doodle_move_ctrl.sv
// ============================================================================
// Module : doodle_move_ctrl
// Horizontal sprite motion: button sync/debounce, last-pressed-wins FSM,
// ramped speed; screen edges wrap when MOVE_WRAP_EN is defined, else clamp.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module doodle_move_ctrl #(
    parameter int DEB_CYCLES = 100_000,
    parameter int TICK_DIV   = 250_000,
    parameter int RAMP_TICKS = 8,
    parameter int MAX_SPEED  = 4,
    parameter int SCREEN_W   = 480,
    parameter int START_X    = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       right_button,
    input  logic       left_button,
    input  logic       run,
    output logic [8:0] shift_h,
    output logic       sprite_choice,
    output logic       moving,
    output logic       edge_hit
);

    localparam int c_DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int c_TICK_W = $clog2(TICK_DIV + 1);
    localparam int c_RAMP_W = $clog2(RAMP_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RIGHT = 2'd1,
        S_LEFT  = 2'd2
    } state_t;

    // Button vectors: bit 0 = right, bit 1 = left, 1 = pressed.
    logic [1:0]              sync1_q, sync2_q, deb_q, deb_d, w_rise;
    logic [1:0][c_DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [c_TICK_W-1:0]     presc_q, presc_d;
    logic                    w_tick;
    state_t                  state_q, state_d;
    logic [8:0]              speed_q, speed_d, shift_q, shift_d;
    logic [c_RAMP_W-1:0]     ramp_q, ramp_d;
    logic                    sprite_q, sprite_d, moving_q, edge_q, edge_d;
    logic                    w_enter;
    logic [8:0]              w_spd, w_diff;
    logic [c_RAMP_W-1:0]     w_ramp;
    logic [9:0]              w_pos, w_sum;

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == c_DEB_W'(DEB_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // The FSM sees the debounced level on the same clock it is accepted.
    assign w_rise  = deb_d & ~deb_q;
    assign w_tick  = (presc_q == c_TICK_W'(TICK_DIV - 1));
    assign presc_d = w_tick ? '0 : presc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        if (!run) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (deb_d[0])      state_d = S_RIGHT;
                    else if (deb_d[1]) state_d = S_LEFT;
                end
                S_RIGHT: begin
                    if (!deb_d[0])     state_d = deb_d[1] ? S_LEFT : S_IDLE;
                    else if (w_rise[1]) state_d = S_LEFT;
                end
                S_LEFT: begin
                    if (!deb_d[1])     state_d = deb_d[0] ? S_RIGHT : S_IDLE;
                    else if (w_rise[0]) state_d = S_RIGHT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_enter  = (state_d != state_q);
        w_spd    = w_enter ? 9'd1 : speed_q;
        w_ramp   = w_enter ? '0 : ramp_q;
        w_pos    = {1'b0, shift_q};
        w_sum    = w_pos + {1'b0, w_spd};
        w_diff   = shift_q - w_spd;
        speed_d  = w_spd;
        ramp_d   = w_ramp;
        shift_d  = shift_q;
        edge_d   = 1'b0;
        sprite_d = sprite_q;
        if (w_enter && state_d == S_RIGHT) sprite_d = 1'b0;
        if (w_enter && state_d == S_LEFT)  sprite_d = 1'b1;

        if (state_d == S_IDLE) begin
            speed_d = '0;
            ramp_d  = '0;
        end else if (w_tick) begin
            if (state_d == S_RIGHT) begin
                if (w_sum >= 10'(SCREEN_W)) begin
`ifdef MOVE_WRAP_EN
                    shift_d = 9'(w_sum - 10'(SCREEN_W));
`else
                    shift_d = 9'(SCREEN_W - 1);
                    edge_d  = 1'b1;
`endif
                end else begin
                    shift_d = w_sum[8:0];
                end
            end else begin
                if (w_pos < {1'b0, w_spd}) begin
`ifdef MOVE_WRAP_EN
                    shift_d = 9'(w_pos + 10'(SCREEN_W) - {1'b0, w_spd});
`else
                    shift_d = '0;
                    edge_d  = 1'b1;
`endif
                end else begin
                    shift_d = w_diff;
                end
            end
            // New speed takes effect from the following tick.
            if (w_ramp == c_RAMP_W'(RAMP_TICKS - 1)) begin
                ramp_d = '0;
                if (w_spd < 9'(MAX_SPEED)) speed_d = w_spd + 9'd1;
            end else begin
                ramp_d = w_ramp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_cnt_q <= '0;
            presc_q   <= '0;
            state_q   <= S_IDLE;
            speed_q   <= '0;
            ramp_q    <= '0;
            shift_q   <= 9'(START_X);
            sprite_q  <= 1'b0;
            moving_q  <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            sync1_q   <= {~left_button, ~right_button};
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            presc_q   <= presc_d;
            state_q   <= state_d;
            speed_q   <= speed_d;
            ramp_q    <= ramp_d;
            shift_q   <= shift_d;
            sprite_q  <= sprite_d;
            moving_q  <= (state_d != S_IDLE);
            edge_q    <= edge_d;
        end
    end

    assign shift_h       = shift_q;
    assign sprite_choice = sprite_q;
    assign moving        = moving_q;
    assign edge_hit      = edge_q;

endmodule

`default_nettype wire
